ifetch_unit: RTL and testbench

//  Instruction-fetch front end; the requester side of the combinational instruction-memory read port.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/ifetch_unit_if.sv | 32 +++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/ifetch_unit.sv | 61 ++++++
 tb/tb_ifetch_unit.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: word width, reset PC and the fetch-buffer entry.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC = '0;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: combinational imem read port plus the decode valid/ready handshake.
interface ifetch_unit_if;
    import cpu_pkg::*;

    word_t imem_addr;
    word_t imem_data;
    logic  if_valid;
    logic  if_ready;
    word_t if_pc;
    word_t if_instr;

    // Fetch unit side.
    modport master (
        output imem_addr,
        input  imem_data,
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready
    );

    // Memory / decode side.
    modport slave (
        input  imem_addr,
        output imem_data,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it and wins over push/pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    // Head is forced to zero while empty so stale storage never reaches decode.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, reads imem combinationally and
// buffers {pc, instr} pairs toward decode; redirect flushes and restarts.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter word_t       RESET_PC   = cpu_pkg::RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    input  logic                 redirect,
    input  word_t                redirect_pc,
    ifetch_unit_if.master        bus
);

    word_t        pc_q, pc_d;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t wdata;
    fetch_entry_t head;

    assign bus.if_valid  = ~empty;
    assign bus.if_pc     = head.pc;
    assign bus.if_instr  = head.instr;
    assign bus.imem_addr = pc_q;

    assign pop   = ~empty & bus.if_ready;
    assign push  = fetch_en & ~redirect & (~full | pop);
    assign wdata = '{pc: pc_q, instr: bus.imem_data};

    // Next PC: redirect target (word aligned) beats sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect)  pc_d = redirect_pc & ~word_t'(3);
        else if (push) pc_d = pc_q + word_t'(4);
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a reference queue of expected fetch
// entries is filled on modelled pushes and drained on decode handshakes.
module tb_ifetch_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic  clk         = 1'b0;
    logic  rst_n       = 1'b0;
    logic  fetch_en    = 1'b0;
    logic  redirect    = 1'b0;
    word_t redirect_pc = '0;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // imem contents: word[i] = 0x100 + i.
    function automatic word_t imem_word(input word_t a);
        return word_t'(32'h100) + (a >> 2);
    endfunction

    assign bus.imem_data = imem_word(bus.imem_addr);

    fetch_entry_t sb[$];
    word_t        m_pc;
    int unsigned  n_checks = 0;
    int unsigned  n_errs   = 0;

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: compare outputs with the model, drive the
    // inputs for the coming rising edge, advance the model, wait one cycle.
    task automatic tick(input logic en, input logic rdy, input logic rd, input word_t rpc);
        fetch_entry_t head;
        logic         pop;
        logic         push;
        head = '0;
        if (sb.size() > 0) head = sb[0];
        check_eq("if_valid",  word_t'(bus.if_valid), word_t'(sb.size() > 0));
        check_eq("imem_addr", bus.imem_addr, m_pc);
        check_eq("if_pc",     bus.if_pc, head.pc);
        check_eq("if_instr",  bus.if_instr, head.instr);

        fetch_en     = en;
        bus.if_ready = rdy;
        redirect     = rd;
        redirect_pc  = rpc;

        pop  = (sb.size() > 0) && rdy;
        push = en && !rd && ((sb.size() < DEPTH) || pop);
        if (rd) begin
            sb.delete();
            m_pc = rpc & ~word_t'(3);
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                sb.push_back('{pc: m_pc, instr: imem_word(m_pc)});
                m_pc = m_pc + word_t'(4);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.if_ready = 1'b0;
        m_pc = RESET_PC;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Streaming after reset release.
        repeat (6) tick(1'b1, 1'b1, 1'b0, '0);

        // Backpressure from pc 0: fill, hold, then drain in order.
        tick(1'b1, 1'b1, 1'b1, 32'h0);
        repeat (5) tick(1'b1, 1'b0, 1'b0, '0);
        repeat (5) tick(1'b1, 1'b1, 1'b0, '0);

        // Redirect to an unaligned target while the buffer is full.
        tick(1'b1, 1'b1, 1'b1, 32'h0);
        repeat (2) tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b1, 32'h43);
        repeat (3) tick(1'b1, 1'b1, 1'b0, '0);

        // Fetch disabled: drain and freeze, then resume.
        repeat (3) tick(1'b0, 1'b1, 1'b0, '0);
        repeat (3) tick(1'b1, 1'b1, 1'b0, '0);

        // Redirect while fetch disabled still flushes and moves the PC.
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b1, 32'h200);
        repeat (2) tick(1'b1, 1'b1, 1'b0, '0);

        // Address wrap.
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (4) tick(1'b1, 1'b1, 1'b0, '0);

        // Mixed random traffic.
        for (int i = 0; i < 60; i++) begin
            tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, word_t'($urandom));
        end
        repeat (2) tick(1'b1, 1'b0, 1'b0, '0);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", word_t'(bus.if_valid), '0);
        check_eq("rst_addr",  bus.imem_addr, RESET_PC);
        check_eq("rst_pc",    bus.if_pc, '0);
        sb.delete();
        m_pc     = RESET_PC;
        fetch_en = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
